// File: rtl/mxpl_stream.sv
// rtl/mxpl_stream.sv - streaming max/average pooling unit with optional ReLU clamp
module mxpl_stream #(
    parameter int DATAW = 20,
    parameter int WIN   = 4,
    parameter int CNTW  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DATAW-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DATAW-1:0] out_data
);

    localparam int              SUMW   = DATAW + CNTW;
    localparam bit              AVG_OK = ((WIN & (WIN - 1)) == 0);
    localparam int              SHIFT  = $clog2(WIN);
    localparam logic [CNTW-1:0] LAST   = CNTW'(WIN - 1);

    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic signed [SUMW-1:0]  acc_q, acc_d;
    logic [1:0]              mode_q, mode_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [DATAW-1:0] out_data_q, out_data_d;

    logic                    accept;
    logic                    first_beat;
    logic                    last_beat;
    logic [1:0]              mode_eff;
    logic                    avg_en;
    logic signed [SUMW-1:0]  in_ext;
    logic signed [SUMW-1:0]  acc_new;
    logic signed [DATAW-1:0] pool_res;
    logic signed [DATAW-1:0] final_res;

    // Only the completing beat has to wait for a pending result to drain.
    assign in_ready   = !flush && !(out_valid_q && !out_ready && (cnt_q == LAST));
    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST);
    // The first beat of a window uses the live mode; later beats use the captured one.
    assign mode_eff   = first_beat ? mode : mode_q;
    assign avg_en     = AVG_OK && mode_eff[0];
    assign in_ext     = {{CNTW{in_data[DATAW-1]}}, in_data};
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // Accumulator update and final result for the beat currently offered.
    always_comb begin
        acc_new   = acc_q;
        pool_res  = '0;
        final_res = '0;
        if (first_beat) begin
            acc_new = in_ext;
        end else if (avg_en) begin
            acc_new = acc_q + in_ext;
        end else if (in_ext > acc_q) begin
            acc_new = in_ext;
        end
        if (avg_en) begin
            pool_res = DATAW'(acc_new >>> SHIFT);
        end else begin
            pool_res = DATAW'(acc_new);
        end
        final_res = (mode_eff[1] && pool_res[DATAW-1]) ? '0 : pool_res;
    end

    // Next-state for window counter, accumulator, captured mode and output register.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (first_beat) begin
                mode_d = mode;
            end
            acc_d = acc_new;
            cnt_d = last_beat ? '0 : cnt_q + CNTW'(1);
        end
        if (accept && last_beat) begin
            out_valid_d = 1'b1;
            out_data_d  = final_res;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: doc/mxpl_stream.md
Name: mxpl_stream

Overview:
- Parametrised streaming pooling unit; successor to the fixed 2x2 signed max-pool subunit.
- Consumes convolution outputs one sample per accepted beat and reduces every WIN consecutive samples to one result.
- Per-window runtime selection of max or average pooling, plus optional ReLU clamp.
- Sits between the convolution engine and the feature-map writeback; valid/ready on both sides so writeback stalls propagate back to the convolution engine.

Parameters:
- DATAW, 20, signed two's-complement sample and result width.
- WIN, 4, samples per pooling window (legal 2..16; 4 = 2x2, 9 = 3x3).
- CNTW, 4, window counter width; must satisfy 2^CNTW >= WIN.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-low.
- flush  input  1  abort the partial window (synchronous).
- mode  input  2  bit0 = average (0 = max), bit1 = ReLU enable.
- in_valid  input  1  in_data valid.
- in_ready  output  1  unit can accept a sample this cycle.
- in_data  input  DATAW  signed convolution output.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATAW  signed pooled result.

Behaviour:
- Reset: reset sampled low at a rising edge clears the window counter, accumulator, mode_q, out_valid and out_data to 0. in_ready is combinational and is therefore 1 while out_valid = 0. Reset has priority over everything, including mid-window and a pending output.
- Beat acceptance: a beat is accepted when in_valid & in_ready.
- Window counter: cnt runs 0..WIN-1 and increments on each accepted beat. On an accepted beat at cnt = WIN-1 the window completes and cnt wraps to 0.
- Mode capture: mode is sampled into mode_q on the accepted beat with cnt = 0. Changes to mode mid-window have no effect on that window.
- Max mode: the accumulator loads the sample at cnt = 0, then becomes the signed max(acc, in_data) on each later beat. Ties keep the existing value.
- Average mode: the sum is held in DATAW+CNTW bits, signed, with no overflow. The result is sum >>> log2(WIN), an arithmetic shift (floor toward negative infinity), truncated to DATAW bits. It is legal only when WIN is a power of two. Otherwise mode_q[0] is ignored and max is used.
- ReLU: if mode_q[1] = 1, a negative final result is replaced by 0.
- Output latency: the final result is computed from the accumulator and the completing beat. It is registered into out_data with out_valid = 1 on the edge that accepts the completing beat, so it is visible the next cycle.
- Output hold: out_data and out_valid stay stable while out_valid & !out_ready. out_valid clears on the out_valid & out_ready edge, unless a new window completes on the same edge.
- Same-edge consume and complete: the new result is loaded and out_valid stays 1.
- in_ready: in_ready = !flush & !(out_valid & !out_ready & cnt == WIN-1). Only the completing beat stalls; beats 0..WIN-2 of the next window are accepted while a result is pending.
- Flush: flush = 1 at an edge clears cnt and the accumulator. Any in_valid beat that cycle is discarded, since in_ready is 0. A pending output is unaffected. When flush and the output handshake coincide, both take effect.
- Counter boundaries: cnt never exceeds WIN-1. With WIN = 16 and CNTW = 4 the counter wraps naturally from 15 to 0.

Test Plan:
- Max pooling (WIN=4, mode=00), out_ready=1: in {-5, 3, -7, 2} -> out_valid=1 for one cycle, out_data=3, one cycle after the 4th beat.
- Average with floor (mode=01): in {-1, -2, -2, -2} -> sum -7 -> out_data=-2. Then in {4, 4, 4, 7} -> sum 19 -> out_data=4.
- ReLU (mode=10 vs 00): in {-5, -3, -9, -4} -> out_data=0 with ReLU, -3 without. A mode change after beat 0 does not alter the window result.
- Backpressure with out_ready=0:
  - After window 1 completes, window 2 beats 0..2 are accepted and in_ready drops at cnt=3.
  - out_data holds window 1's result.
  - Raising out_ready for one cycle consumes the result; in_ready=1 that same cycle, the completing beat is accepted, and window 2's result is loaded the next cycle.
- Flush and reset mid-window:
  - Flush after 2 beats, then in {1, 2, 3, 4} -> out_data=4 with no contamination from the earlier beats.
  - reset=0 after 3 beats with out_valid=1 -> all outputs 0 next cycle and the next window starts at cnt 0.
- WIN=9 build: nine samples -> their signed max. With mode=01 the unit still returns the max (average ignored).
